// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared instruction-memory constants, bus widths and init FSM encoding.
// Rev 1.0
`default_nettype none

package cpu_mem_pkg;

    localparam logic [31:0] INST_BASE_ADDR = 32'hbfc0_0000;
    localparam int          SRAM_DATA_W    = 32;
    localparam int          SRAM_WEN_W     = 4;

    localparam int          ST_W     = 1;
    localparam logic [ST_W-1:0] ST_INIT  = 1'b0;
    localparam logic [ST_W-1:0] ST_READY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sram_word_array.sv
// sram_word_array: single-port byte-lane-writable word array, registered read-first output.
// Rev 1.0
`default_nettype none

module sram_word_array
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we_i,
    input  logic [SRAM_WEN_W-1:0]  be_i,
    input  logic [ADDR_WIDTH-1:0]  idx_i,
    input  logic [SRAM_DATA_W-1:0] wdata_i,
    input  logic                   rd_i,
    input  logic                   zero_i,
    output logic [SRAM_DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [SRAM_DATA_W-1:0] mem_q [DEPTH];
    logic [SRAM_DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < SRAM_WEN_W; i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Output register samples the word before this cycle's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_i) begin
            rdata_q <= zero_i ? '0 : mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/inst_sram_responder.sv
// inst_sram_responder: fetch-side instruction SRAM responder with window check and zero-fill init.
// Rev 1.0
`default_nettype none

module inst_sram_responder
    import cpu_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 12,
    parameter logic [31:0] BASE_ADDR      = INST_BASE_ADDR,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [SRAM_WEN_W-1:0]  wen,
    input  logic [31:0]            addr,
    input  logic [SRAM_DATA_W-1:0] wdata,
    output logic [SRAM_DATA_W-1:0] rdata,
    output logic                   addr_err,
    output logic                   busy
);

    localparam logic [ST_W-1:0]       RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_READY;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;

    logic [ST_W-1:0]        state_q, state_d;
    logic [ADDR_WIDTH-1:0]  clr_idx_q, clr_idx_d;
    logic                   addr_err_q, addr_err_d;

    logic [31:0]            off_w;
    logic                   valid_w;
    logic [ADDR_WIDTH-1:0]  word_idx_w;

    logic                   arr_we_w;
    logic [SRAM_WEN_W-1:0]  arr_be_w;
    logic [ADDR_WIDTH-1:0]  arr_idx_w;
    logic [SRAM_DATA_W-1:0] arr_wdata_w;
    logic                   arr_rd_w;
    logic                   arr_zero_w;

    // Window check: word-aligned and below BASE_ADDR + 4*2^ADDR_WIDTH.
    assign off_w      = addr - BASE_ADDR;
    assign valid_w    = (addr[1:0] == 2'b00) && ((off_w >> (ADDR_WIDTH + 2)) == 32'd0);
    assign word_idx_w = off_w[ADDR_WIDTH+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RST_STATE;
            clr_idx_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_INIT: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    always_comb begin
        arr_we_w    = 1'b0;
        arr_be_w    = '0;
        arr_idx_w   = word_idx_w;
        arr_wdata_w = wdata;
        arr_rd_w    = 1'b0;
        arr_zero_w  = 1'b0;
        addr_err_d  = addr_err_q;
        case (state_q)
            ST_INIT: begin
                arr_we_w    = ~rst;
                arr_be_w    = '1;
                arr_idx_w   = clr_idx_q;
                arr_wdata_w = '0;
            end
            default: begin
                // Idle cycles leave rdata/addr_err untouched so fetch stalls see stable data.
                if (en && !rst) begin
                    arr_rd_w   = 1'b1;
                    arr_zero_w = ~valid_w;
                    arr_we_w   = valid_w && (wen != '0);
                    arr_be_w   = wen;
                    addr_err_d = ~valid_w;
                end
            end
        endcase
    end

    sram_word_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (arr_we_w),
        .be_i    (arr_be_w),
        .idx_i   (arr_idx_w),
        .wdata_i (arr_wdata_w),
        .rd_i    (arr_rd_w),
        .zero_i  (arr_zero_w),
        .rdata_o (rdata)
    );

    assign addr_err = addr_err_q;
    assign busy     = (state_q == ST_INIT);

endmodule

`default_nettype wire
